// File: rtl/ghost_ai_pkg.sv
// Shared types and constants for the ghost AI driver.
//   dir_t   : direction command (DirNone means "no direction yet" / no pulse)
//   mode_t  : driver mode, encoded as presented on the mode output
//   Idx*    : bit positions in the 4-bit enable vector, clockwise from up
//   Lfsr*   : SCATTER pseudo-random source (8-bit Fibonacci, taps 8,6,5,4)
package ghost_ai_pkg;

  typedef enum logic [2:0] {
    DirNone  = 3'd0,
    DirUp    = 3'd1,
    DirRight = 3'd2,
    DirDown  = 3'd3,
    DirLeft  = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    ModeIdle    = 2'd0,
    ModeChase   = 2'd1,
    ModeScatter = 2'd2,
    ModeHalt    = 2'd3
  } mode_t;

  // Clockwise order; also the SCATTER scan order before rotation.
  localparam logic [1:0] IdxUp    = 2'd0;
  localparam logic [1:0] IdxRight = 2'd1;
  localparam logic [1:0] IdxDown  = 2'd2;
  localparam logic [1:0] IdxLeft  = 2'd3;

  localparam logic [7:0] LfsrSeed = 8'hA5;
  // Taps 8,6,5,4 (1-based) are bits 7,5,4,3.
  localparam logic [7:0] LfsrTaps = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LfsrTaps)};
  endfunction

  // Enable-vector index to direction; dir_t values follow index order offset by one.
  function automatic dir_t dir_from_idx(input logic [1:0] idx);
    return dir_t'({1'b0, idx} + 3'd1);
  endfunction

endpackage

// File: rtl/ghost_dir_select.sv
// Combinational direction chooser.
//   en       : legal moves, indexed by IdxUp/IdxRight/IdxDown/IdxLeft
//   dx, dy   : signed pacman-minus-ghost deltas (y grows downward)
//   mode     : ModeChase steers toward pacman, ModeScatter uses the LFSR rotation,
//              any other mode yields DirNone
//   lfsr_low : low two LFSR bits, the SCATTER scan start index
//   last_dir : last issued direction; its opposite is avoided unless it is the only move
//   dir      : chosen direction, DirNone when nothing is legal
module ghost_dir_select
  import ghost_ai_pkg::*;
(
  input  logic        [3:0] en,
  input  logic signed [10:0] dx,
  input  logic signed [9:0]  dy,
  input  mode_t              mode,
  input  logic        [1:0]  lfsr_low,
  input  dir_t               last_dir,
  output dir_t               dir
);

  logic [3:0]  rev_mask;
  logic [3:0]  allowed;
  logic [10:0] adx;
  logic [9:0]  ady;
  logic        horiz;
  logic        p_ok, s_ok;
  logic [1:0]  p_idx, s_idx;
  logic [1:0]  rot_idx;

  always_comb begin
    rev_mask = 4'b0000;
    case (last_dir)
      DirUp:    rev_mask[IdxDown]  = 1'b1;
      DirRight: rev_mask[IdxLeft]  = 1'b1;
      DirDown:  rev_mask[IdxUp]    = 1'b1;
      DirLeft:  rev_mask[IdxRight] = 1'b1;
      default:  rev_mask = 4'b0000;
    endcase
    // Reversing is only allowed when it is the single legal move.
    if (rev_mask != 4'b0000 && en == rev_mask) begin
      allowed = en;
    end else begin
      allowed = en & ~rev_mask;
    end
  end

  always_comb begin
    adx   = dx[10] ? 11'(-dx) : 11'(dx);
    ady   = dy[9]  ? 10'(-dy) : 10'(dy);
    horiz = adx >= {1'b0, ady};
    // A zero delta on an axis contributes no candidate on that axis.
    if (horiz) begin
      p_ok  = dx != 11'sd0;
      p_idx = dx[10] ? IdxLeft : IdxRight;
      s_ok  = dy != 10'sd0;
      s_idx = dy[9] ? IdxUp : IdxDown;
    end else begin
      p_ok  = dy != 10'sd0;
      p_idx = dy[9] ? IdxUp : IdxDown;
      s_ok  = dx != 11'sd0;
      s_idx = dx[10] ? IdxLeft : IdxRight;
    end
  end

  always_comb begin
    dir     = DirNone;
    rot_idx = 2'd0;
    if (mode == ModeChase) begin
      if (p_ok && allowed[p_idx]) begin
        dir = dir_from_idx(p_idx);
      end else if (s_ok && allowed[s_idx]) begin
        dir = dir_from_idx(s_idx);
      end else if (allowed[IdxUp]) begin
        dir = DirUp;
      end else if (allowed[IdxLeft]) begin
        dir = DirLeft;
      end else if (allowed[IdxDown]) begin
        dir = DirDown;
      end else if (allowed[IdxRight]) begin
        dir = DirRight;
      end
    end else if (mode == ModeScatter) begin
      for (int i = 0; i < 4; i++) begin
        rot_idx = lfsr_low + 2'(i);
        if (dir == DirNone && allowed[rot_idx]) begin
          dir = dir_from_idx(rot_idx);
        end
      end
    end
  end

endmodule

// File: rtl/ghost_ai_driver.sv
// Ghost AI driver: issues one-cycle direction pulses to a ghost block every
// DECIDE_PERIOD clocks, alternating CHASE and SCATTER phases.
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   go                      : level, starts play from IDLE
//   win, loose              : game over, forces HALT until reset
//   uE, dE, rE, lE          : legal-move flags for the ghost's current tile
//   xGhost/yGhost, xPac/yPac: positions (10-bit x, 9-bit y)
//   up, down, left, right   : registered direction pulses
//   start                   : registered one-cycle pulse on leaving IDLE
//   mode                    : 0 IDLE, 1 CHASE, 2 SCATTER, 3 HALT
module ghost_ai_driver
  import ghost_ai_pkg::*;
#(
  parameter int unsigned DECIDE_PERIOD     = 1_000_000,
  parameter int unsigned CHASE_DECISIONS   = 20,
  parameter int unsigned SCATTER_DECISIONS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       win,
  input  logic       loose,
  input  logic       uE,
  input  logic       dE,
  input  logic       rE,
  input  logic       lE,
  input  logic [9:0] xGhost,
  input  logic [8:0] yGhost,
  input  logic [9:0] xPac,
  input  logic [8:0] yPac,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       start,
  output logic [1:0] mode
);

  localparam int unsigned TickW  = $clog2(DECIDE_PERIOD);
  localparam int unsigned DecMax = (CHASE_DECISIONS > SCATTER_DECISIONS) ?
                                   CHASE_DECISIONS : SCATTER_DECISIONS;
  localparam int unsigned DecW   = (DecMax > 1) ? $clog2(DecMax) : 1;

  localparam logic [TickW-1:0] TickLast    = TickW'(DECIDE_PERIOD - 1);
  localparam logic [DecW-1:0]  ChaseLast   = DecW'(CHASE_DECISIONS - 1);
  localparam logic [DecW-1:0]  ScatterLast = DecW'(SCATTER_DECISIONS - 1);

  mode_t              state_q;
  logic [TickW-1:0]   tick_q;
  logic [DecW-1:0]    dec_q;
  logic [7:0]         lfsr_q;
  dir_t               last_q;

  logic signed [10:0] dx;
  logic signed [9:0]  dy;
  logic [3:0]         en;
  dir_t               sel;
  logic               decide;
  logic               phase_done;

  assign dx = 11'({1'b0, xPac}) - 11'({1'b0, xGhost});
  assign dy = 10'({1'b0, yPac}) - 10'({1'b0, yGhost});

  always_comb begin
    en          = 4'b0000;
    en[IdxUp]    = uE;
    en[IdxRight] = rE;
    en[IdxDown]  = dE;
    en[IdxLeft]  = lE;
  end

  assign decide     = (state_q == ModeChase || state_q == ModeScatter) && tick_q == TickLast;
  assign phase_done = dec_q == ((state_q == ModeChase) ? ChaseLast : ScatterLast);
  assign mode       = state_q;

  ghost_dir_select u_dir_select (
    .en       (en),
    .dx       (dx),
    .dy       (dy),
    .mode     (state_q),
    .lfsr_low (lfsr_q[1:0]),
    .last_dir (last_q),
    .dir      (sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ModeIdle;
      tick_q  <= '0;
      dec_q   <= '0;
      lfsr_q  <= LfsrSeed;
      last_q  <= DirNone;
      up      <= 1'b0;
      down    <= 1'b0;
      left    <= 1'b0;
      right   <= 1'b0;
      start   <= 1'b0;
    end else begin
      // All command outputs are single-cycle pulses.
      up    <= 1'b0;
      down  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
      start <= 1'b0;
      if (win || loose) begin
        // Game over wins over any pending decision or start.
        state_q <= ModeHalt;
        tick_q  <= '0;
        dec_q   <= '0;
      end else begin
        unique case (state_q)
          ModeIdle: begin
            if (go) begin
              state_q <= ModeChase;
              tick_q  <= '0;
              dec_q   <= '0;
              start   <= 1'b1;
            end
          end
          ModeChase, ModeScatter: begin
            if (decide) begin
              tick_q <= '0;
              up     <= sel == DirUp;
              down   <= sel == DirDown;
              left   <= sel == DirLeft;
              right  <= sel == DirRight;
              if (sel != DirNone) begin
                last_q <= sel;
              end
              if (state_q == ModeScatter) begin
                lfsr_q <= lfsr_next(lfsr_q);
              end
              // The phase-switching decision still issues its pulse above.
              if (phase_done) begin
                state_q <= (state_q == ModeChase) ? ModeScatter : ModeChase;
                dec_q   <= '0;
              end else begin
                dec_q <= dec_q + DecW'(1);
              end
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
          ModeHalt: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ghost_ai_driver.sv
module tb_ghost_ai_driver;

  localparam int DP = 4;
  localparam int CD = 2;
  localparam int SD = 1;

  logic       clk = 1'b0;
  logic       reset, go, win, loose;
  logic       uE, dE, rE, lE;
  logic [9:0] xGhost, xPac;
  logic [8:0] yGhost, yPac;
  logic       up, down, left, right, start;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;

  // Decision-level model state: mode, decisions in phase, LFSR, last direction
  // (directions: 0 none, 1 up, 2 right, 3 down, 4 left).
  int m_mode, m_dec, m_lfsr, m_last;

  always #5 clk = ~clk;

  ghost_ai_driver #(
    .DECIDE_PERIOD     (DP),
    .CHASE_DECISIONS   (CD),
    .SCATTER_DECISIONS (SD)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .win    (win),
    .loose  (loose),
    .uE     (uE),
    .dE     (dE),
    .rE     (rE),
    .lE     (lE),
    .xGhost (xGhost),
    .yGhost (yGhost),
    .xPac   (xPac),
    .yPac   (yPac),
    .up     (up),
    .down   (down),
    .left   (left),
    .right  (right),
    .start  (start),
    .mode   (mode)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [3:0] urdl);
    {uE, rE, dE, lE} = urdl;
  endtask

  task automatic set_pos(input int xg, input int yg, input int xp, input int yp);
    xGhost = 10'(xg);
    yGhost = 9'(yg);
    xPac   = 10'(xp);
    yPac   = 9'(yp);
  endtask

  // Expected {mode, start, up, right, down, left}.
  function automatic logic [6:0] expv(input int m, input bit s, input int d);
    logic [3:0] oh;
    oh = (d == 0) ? 4'b0000 : (4'b1000 >> (d - 1));
    return {2'(m), s, oh};
  endfunction

  task automatic chk(input string tag, input logic [6:0] e);
    logic [6:0] o;
    o = {mode, start, up, right, down, left};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed mode/start/urdl=%b expected=%b", tag, o, e);
    end
  endtask

  function automatic int lfsr_step(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | fb) & 255;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Direction choice straight from the rules: candidate list, then first legal one.
  function automatic int ref_pick(input int m, input logic [3:0] urdl, input int xg,
                                  input int yg, input int xp, input int yp,
                                  input int lf, input int last);
    int c[$];
    int opp, dx, dy, cnt;
    opp = (last == 0) ? 0 : ((last + 1) % 4) + 1;
    cnt = int'(urdl[3]) + int'(urdl[2]) + int'(urdl[1]) + int'(urdl[0]);
    dx  = xp - xg;
    dy  = yp - yg;
    if (m == 1) begin
      if (iabs(dx) >= iabs(dy)) begin
        if (dx > 0) c.push_back(2); else if (dx < 0) c.push_back(4);
        if (dy > 0) c.push_back(3); else if (dy < 0) c.push_back(1);
      end else begin
        if (dy > 0) c.push_back(3); else if (dy < 0) c.push_back(1);
        if (dx > 0) c.push_back(2); else if (dx < 0) c.push_back(4);
      end
      c.push_back(1);
      c.push_back(4);
      c.push_back(3);
      c.push_back(2);
    end else if (m == 2) begin
      for (int i = 0; i < 4; i++) c.push_back(((lf & 3) + i) % 4 + 1);
    end
    foreach (c[k]) begin
      if (urdl[4 - c[k]] && (c[k] != opp || cnt == 1)) return c[k];
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_dec  = 0;
    m_lfsr = 'hA5;
    m_last = 0;
  endtask

  task automatic model_decide(input int d);
    if (d != 0) m_last = d;
    if (m_mode == 2) m_lfsr = lfsr_step(m_lfsr);
    m_dec++;
    if (m_mode == 1 && m_dec == CD) begin
      m_mode = 2;
      m_dec  = 0;
    end else if (m_mode == 2 && m_dec == SD) begin
      m_mode = 1;
      m_dec  = 0;
    end
  endtask

  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, expv(m_mode, 1'b0, 0));
    end
  endtask

  // One full decision period; want < 0 takes the reference model's choice.
  task automatic run_dec(input string tag, input int want);
    int d;
    quiet(DP - 1, {tag, "_wait"});
    d = (want < 0) ? ref_pick(m_mode, {uE, rE, dE, lE}, int'(xGhost), int'(yGhost),
                              int'(xPac), int'(yPac), m_lfsr, m_last) : want;
    model_decide(d);
    tick();
    chk(tag, expv(m_mode, 1'b0, d));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    go    = 1'b0;
    tick();
    tick();
    model_reset();
    chk("reset_state", expv(0, 1'b0, 0));
    reset = 1'b0;
  endtask

  task automatic start_play();
    go = 1'b1;
    tick();
    m_mode = 1;
    m_dec  = 0;
    chk("start", expv(1, 1'b1, 0));
    go = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    win   = 1'b0;
    loose = 1'b0;
    set_en(4'b1111);
    set_pos(10, 10, 50, 20);
    model_reset();

    // Start, chase toward pacman, phase switch, first SCATTER pick from seed.
    do_reset();
    start_play();
    run_dec("chase_right", 2);
    set_en(4'b1011);
    run_dec("chase_down", 3);
    set_en(4'b1111);
    run_dec("scatter_first", -1);

    // Game over on a decision cycle; go is then ignored.
    quiet(DP - 1, "pre_loose");
    loose = 1'b1;
    tick();
    m_mode = 3;
    chk("loose_halt", expv(3, 1'b0, 0));
    loose = 1'b0;
    go    = 1'b1;
    quiet(5, "halt_hold");
    go = 1'b0;

    // Reverse is taken when it is the only legal move.
    do_reset();
    set_pos(10, 10, 50, 20);
    set_en(4'b1111);
    start_play();
    run_dec("b_right", 2);
    set_en(4'b0001);
    run_dec("reverse_sole", 4);

    // Reverse is blocked when anything else is legal.
    do_reset();
    set_pos(10, 10, 50, 20);
    set_en(4'b1111);
    start_play();
    run_dec("c_right", 2);
    set_pos(10, 10, 0, 10);
    set_en(4'b1001);
    run_dec("reverse_blocked", 1);

    // Nothing legal: no pulse, decision still counts.
    set_en(4'b0000);
    run_dec("no_enable", 0);

    // Ghost on pacman: fallback order.
    set_pos(100, 100, 100, 100);
    set_en(4'b0110);
    run_dec("zero_delta", -1);

    // Reset on a decision cycle and during the start pulse.
    quiet(DP - 1, "pre_reset");
    reset = 1'b1;
    tick();
    model_reset();
    chk("reset_on_decision", expv(0, 1'b0, 0));
    reset = 1'b0;
    go    = 1'b1;
    tick();
    m_mode = 1;
    chk("start_again", expv(1, 1'b1, 0));
    reset = 1'b1;
    go    = 1'b0;
    tick();
    model_reset();
    chk("reset_on_start", expv(0, 1'b0, 0));
    reset = 1'b0;

    // Random positions, enables and go against the reference model.
    start_play();
    for (int n = 0; n < 40; n++) begin
      set_pos($urandom_range(0, 1023), $urandom_range(0, 511),
              $urandom_range(0, 1023), $urandom_range(0, 511));
      set_en(4'($urandom_range(0, 15)));
      go = 1'($urandom_range(0, 1));
      run_dec("rand", -1);
    end
    go = 1'b0;

    // Win outside a decision cycle.
    win = 1'b1;
    tick();
    m_mode = 3;
    chk("win_halt", expv(3, 1'b0, 0));
    win = 1'b0;
    quiet(3, "win_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ghost_ai_driver.md
GHOST_AI_DRIVER -- requirements
Module: ghost_ai_driver

Interface
REQ-001 Parameter DECIDE_PERIOD, 1_000_000, clocks between direction decisions (>=2).
REQ-002 Parameter CHASE_DECISIONS, 20, decisions spent in CHASE before switching to SCATTER.
REQ-003 Parameter SCATTER_DECISIONS, 7, decisions spent in SCATTER before returning to CHASE.
REQ-004 clk  input  1  single system clock, all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 go  input  1  level; begins ghost play when high in IDLE.
REQ-007 win, loose  input  1 each  game-over flags.
REQ-008 uE, dE, rE, lE  input  1 each  maze says move in that direction is legal from the ghost's current tile.
REQ-009 xGhost  input  10, yGhost  input  9  current ghost position.
REQ-010 xPac  input  10, yPac  input  9  current pacman position.
REQ-011 up, down, left, right, start  output  1 each  registered command pulses into the ghost block.
REQ-012 mode  output  2  current mode: 0 IDLE, 1 CHASE, 2 SCATTER, 3 HALT.

Function
REQ-013 FSM states IDLE, CHASE, SCATTER, HALT; IDLE->CHASE when go=1, with start=1 for exactly the cycle after go is sampled.
REQ-014 Tick counter counts 0..DECIDE_PERIOD-1 in CHASE/SCATTER only, wraps, and cleared on every mode entry; a decision occurs at count DECIDE_PERIOD-1.
REQ-015 On a decision, exactly one of up/down/left/right is 1 for one cycle, registered (visible the cycle after the decision); all four are 0 otherwise.
REQ-016 If no direction is enabled at a decision, no pulse is issued and last direction is unchanged.
REQ-017 Reverse rule: the opposite of the last issued direction is chosen only if it is the sole enabled direction.
REQ-018 CHASE: dx=xPac-xGhost (11-bit signed), dy=yPac-yGhost (10-bit signed); primary axis is horizontal when |dx|>=|dy|, else vertical.
REQ-019 CHASE priority: primary-axis direction toward pacman, then secondary-axis direction toward pacman (skipped if that delta is 0), then first legal of up,left,down,right; each candidate must be enabled and non-reverse.
REQ-020 SCATTER: 8-bit Fibonacci LFSR, taps 8,6,5,4, advances once per decision; scan order up,right,down,left rotated to start at index lfsr[1:0]; first enabled non-reverse direction wins.
REQ-021 Decision counter: after CHASE_DECISIONS decisions in CHASE go to SCATTER; after SCATTER_DECISIONS in SCATTER go to CHASE; the switching decision still issues its pulse.
REQ-022 win or loose high in any state -> HALT next cycle; HALT outputs all zeros and is left only by reset.
REQ-023 win/loose on a decision cycle suppresses that pulse.
REQ-024 go ignored outside IDLE; dx=dy=0 in CHASE selects horizontal-axis fallback per REQ-019 (first legal of up,left,down,right).

Reset
REQ-025 Reset: state IDLE, mode=0, all outputs 0, tick and decision counters 0, LFSR 8'hA5, last direction NONE (no reverse restriction).
REQ-026 Reset mid-decision or mid-start-pulse clears the pending pulse in the next cycle.

Structure
REQ-027 Package ghost_ai_pkg holds dir_t (NONE, UP, RIGHT, DOWN, LEFT), mode_t, LFSR seed and tap constants.
REQ-028 Combinational sub-module ghost_dir_select takes enables, dx/dy, mode, lfsr, last dir and returns dir_t; ghost_ai_driver holds all registers.

Verification (DECIDE_PERIOD=4, CHASE_DECISIONS=2, SCATTER_DECISIONS=1)
REQ-029 Reset, go=1 at cycle 0 -> start=1 at cycle 1 only, mode=1; first direction pulse 4 cycles after CHASE entry.
REQ-030 xGhost=10,yGhost=10,xPac=50,yPac=20, all enables 1 -> right pulse; with rE=0 -> down pulse.
REQ-031 Last dir RIGHT, only lE=1 -> left; lE=1 and uE=1, pacman at left -> up (reverse blocked).
REQ-032 After 2 CHASE decisions mode=2; LFSR from 8'hA5 drives first SCATTER pick, verified against reference model; after 1 decision mode=1.
REQ-033 loose=1 on a decision cycle -> no pulse, mode=3 next cycle, go ignored until reset.
REQ-034 All enables 0 at decision -> no pulse; reset asserted the cycle of a decision -> all outputs 0 next cycle, mode=0.
